axis_level_sequencer: RTL and testbench
=======================================

Name: axis_level_sequencer

Overview:
- Parametrised successor to the fixed two-level AXIS constant source.
- Emits a signed level on an AXI-Stream master. The level is selected by the state_data input, and both levels are run-time configurable.
- Adds a debounce/hold time on state changes, slew-limited ramping between levels, and full tready back-pressure.
- Feeds threshold/comparator and DAC paths in the 10-bit acquisition chain.

Parameters:
- AXIS_TDATA_WIDTH, 32: output bus width; the level is sign-extended into it.
- LEVEL_WIDTH, 16: signed level width; must be ≤ AXIS_TDATA_WIDTH.
- STEP_WIDTH, 8: unsigned slew-step width.
- HOLD_WIDTH, 16: debounce counter width.
- IDLE_RESET, -1: level register value while in reset.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- state_data  in  1  level select, asynchronous to aclk; 1 = active, 0 = idle.
- cfg_active_level  in  LEVEL_WIDTH  signed active target; quasi-static.
- cfg_idle_level  in  LEVEL_WIDTH  signed idle target; quasi-static.
- cfg_step  in  STEP_WIDTH  max change per accepted beat; 0 = immediate jump.
- cfg_hold  in  HOLD_WIDTH  cycles state_data must be stable before commit.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  sign-extended current level.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high when FSM is not in STEADY.

Behaviour:
- Reset (async assert, sync release inside aclk domain):
  - level = IDLE_RESET; committed_state = 0; FSM = STEADY.
  - Counter = 0; tvalid = 0; busy = 0; synchroniser flops = 0.
- tvalid rises 1 cycle after reset release and then stays 1.
- state_data passes through a 2-FF synchroniser; s_sync lags the pin by 2 cycles.
- target = committed_state ? cfg_active_level : cfg_idle_level.
- FSM states: STEADY, DEBOUNCE, RAMP.
- STEADY (level == target, s_sync == committed_state):
  - s_sync != committed_state -> DEBOUNCE, counter = cfg_hold.
  - Otherwise level != target (cfg change) -> RAMP.
- DEBOUNCE:
  - Counter decrements every cycle, independent of tready.
  - s_sync == committed_state (glitch revert) -> STEADY if level == target, else RAMP; no commit.
  - Counter == 0 and s_sync still differs -> committed_state = s_sync, go to RAMP.
  - cfg_hold = 0 commits on the first DEBOUNCE cycle.
- RAMP:
  - s_sync != committed_state -> DEBOUNCE; the ramp toward the old target continues during DEBOUNCE.
  - level == target -> STEADY.
- Level update, in any state: only on the beat tvalid && tready.
  - diff = target - level, computed signed in LEVEL_WIDTH+1 bits (no overflow).
  - cfg_step == 0 or |diff| ≤ cfg_step: level = target.
  - Otherwise level += sign(diff) * cfg_step.
  - Never overshoots; consecutive transmitted samples differ by ≤ cfg_step.
- Back-pressure: while tvalid && !tready, tdata is held stable and the level does not move; the debounce counter still runs.
- tdata = level sign-extended to AXIS_TDATA_WIDTH.
  - Default idle -1 gives 0xFFFFFFFF.
  - Active 0x02FF gives 0x000002FF.
- Extremes: a full-scale swing, -32768 to 32767 with step 255, completes in ceil(65535/255) = 257 accepted beats.
- Mid-operation reset: output returns immediately and asynchronously to the reset values; the ramp is abandoned.

Decomposition:
- Package axis_level_pkg:
  - FSM state enum (STEADY, DEBOUNCE, RAMP).
  - Local width constant DIFF_WIDTH = LEVEL_WIDTH + 1.
  - Default level constants: 16'h02FF active, -1 idle.
- One sub-module, level_slew: combinational next-level calculator (level, target, step -> next_level, at_target).
  - Reused by later multi-channel variants.
- The synchroniser stays inline.

Test Plan:
- Reset, then tready = 1, state_data = 0, idle = -1, step = 0 -> tvalid = 1 at cycle 1, tdata = 0xFFFFFFFF, busy = 0.
- state_data 0->1, hold = 4, step = 0, active = 0x02FF -> tdata jumps to 0x000002FF exactly 2 (sync) + 5 cycles after the pin edge, then 1 RAMP beat; busy returns to 0.
- 3-cycle pulse on state_data with hold = 10 -> no commit, tdata stays 0xFFFFFFFF, busy high for ~3 cycles.
- Ramp from -1 to 0x02FF with step = 0x40 -> samples -1, 63, 127, ..., 703, 767 (0x02FF) and no overshoot; reverse ramp is symmetric.
- During ramp, tready low for 5 cycles -> tdata frozen and stable for all 5; ramp resumes with the next value on reassert; no skipped step.
- Assert areset mid-ramp -> tvalid = 0 and level = IDLE_RESET immediately; after release, clean restart from idle.

Source files
------------

// File: rtl/axis_level_pkg.sv
// Shared constants for the AXIS level sequencer family: FSM encoding and default levels.
package axis_level_pkg;

    localparam int unsigned DEF_LEVEL_WIDTH = 16;
    localparam int unsigned DIFF_WIDTH      = DEF_LEVEL_WIDTH + 1;

    localparam logic [1:0] ST_STEADY   = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_RAMP     = 2'd2;

    localparam logic signed [DEF_LEVEL_WIDTH-1:0] DEFAULT_ACTIVE_LEVEL = 16'sh02FF;
    localparam logic signed [DEF_LEVEL_WIDTH-1:0] DEFAULT_IDLE_LEVEL   = -16'sd1;

endpackage

// File: rtl/level_slew.sv
// Combinational slew limiter: moves level toward target by at most step, never overshooting.
module level_slew
    import axis_level_pkg::*;
#(
    parameter int unsigned LEVEL_WIDTH = DEF_LEVEL_WIDTH,
    parameter int unsigned STEP_WIDTH  = 8
) (
    input  logic signed [LEVEL_WIDTH-1:0] level,
    input  logic signed [LEVEL_WIDTH-1:0] target,
    input  logic        [STEP_WIDTH-1:0]  step,
    output logic signed [LEVEL_WIDTH-1:0] next_level,
    output logic                          at_target
);

    localparam int unsigned DW = LEVEL_WIDTH + 1;

    logic signed [DW-1:0]          diff;
    logic        [DW-1:0]          mag;
    logic        [DW-1:0]          step_ext;
    logic signed [LEVEL_WIDTH-1:0] step_lvl;

    // One extra bit keeps the full-scale difference representable.
    always_comb begin
        diff       = DW'(target) - DW'(level);
        mag        = diff[DW-1] ? $unsigned(-diff) : $unsigned(diff);
        step_ext   = DW'(step);
        step_lvl   = LEVEL_WIDTH'(step);
        at_target  = (diff == '0);
        next_level = target;
        if (step != '0 && mag > step_ext) begin
            next_level = diff[DW-1] ? (level - step_lvl) : (level + step_lvl);
        end
    end

endmodule

// File: rtl/axis_level_sequencer.sv
// AXIS source emitting a debounced, slew-limited signed level chosen by state_data.
module axis_level_sequencer
    import axis_level_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned LEVEL_WIDTH      = DEF_LEVEL_WIDTH,
    parameter int unsigned STEP_WIDTH       = 8,
    parameter int unsigned HOLD_WIDTH       = 16,
    parameter int          IDLE_RESET       = int'(DEFAULT_IDLE_LEVEL)
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          state_data,
    input  logic signed [LEVEL_WIDTH-1:0] cfg_active_level,
    input  logic signed [LEVEL_WIDTH-1:0] cfg_idle_level,
    input  logic        [STEP_WIDTH-1:0]  cfg_step,
    input  logic        [HOLD_WIDTH-1:0]  cfg_hold,
    output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          busy
);

    logic                          s_meta;
    logic                          s_sync;
    logic                          committed;
    logic                          committed_nxt;
    logic [1:0]                    state;
    logic [1:0]                    state_nxt;
    logic [HOLD_WIDTH-1:0]         counter;
    logic [HOLD_WIDTH-1:0]         counter_nxt;
    logic signed [LEVEL_WIDTH-1:0] level;
    logic signed [LEVEL_WIDTH-1:0] level_nxt;
    logic signed [LEVEL_WIDTH-1:0] target;
    logic signed [LEVEL_WIDTH-1:0] slew_level;
    logic                          at_target;
    logic                          beat;

    assign target       = committed ? cfg_active_level : cfg_idle_level;
    assign beat         = m_axis_tvalid && m_axis_tready;
    assign m_axis_tdata = AXIS_TDATA_WIDTH'(level);

    level_slew #(
        .LEVEL_WIDTH (LEVEL_WIDTH),
        .STEP_WIDTH  (STEP_WIDTH)
    ) u_slew (
        .level      (level),
        .target     (target),
        .step       (cfg_step),
        .next_level (slew_level),
        .at_target  (at_target)
    );

    // Next-state: debounce runs freely; the level only moves on accepted beats.
    always_comb begin
        state_nxt     = state;
        counter_nxt   = counter;
        committed_nxt = committed;
        level_nxt     = beat ? slew_level : level;
        case (state)
            ST_STEADY: begin
                if (s_sync != committed) begin
                    state_nxt   = ST_DEBOUNCE;
                    counter_nxt = cfg_hold;
                end else if (!at_target) begin
                    state_nxt = ST_RAMP;
                end
            end
            ST_DEBOUNCE: begin
                if (s_sync == committed) begin
                    state_nxt = at_target ? ST_STEADY : ST_RAMP;
                end else if (counter == '0) begin
                    committed_nxt = s_sync;
                    state_nxt     = ST_RAMP;
                end else begin
                    counter_nxt = counter - HOLD_WIDTH'(1);
                end
            end
            ST_RAMP: begin
                if (s_sync != committed) begin
                    state_nxt   = ST_DEBOUNCE;
                    counter_nxt = cfg_hold;
                end else if (at_target) begin
                    state_nxt = ST_STEADY;
                end
            end
            default: state_nxt = ST_STEADY;
        endcase
    end

    // areset is expected to be released synchronously to aclk by the reset tree.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s_meta        <= 1'b0;
            s_sync        <= 1'b0;
            committed     <= 1'b0;
            state         <= ST_STEADY;
            counter       <= '0;
            level         <= LEVEL_WIDTH'(IDLE_RESET);
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            s_meta        <= state_data;
            s_sync        <= s_meta;
            committed     <= committed_nxt;
            state         <= state_nxt;
            counter       <= counter_nxt;
            level         <= level_nxt;
            m_axis_tvalid <= 1'b1;
            busy          <= (state_nxt != ST_STEADY);
        end
    end

endmodule

// File: tb/tb_axis_level_sequencer.sv
// Directed bench for axis_level_sequencer with a cycle-level behavioural reference model.
module tb_axis_level_sequencer;
    import axis_level_pkg::*;

    logic               aclk = 1'b0;
    logic               areset = 1'b1;
    logic               state_data = 1'b0;
    logic signed [15:0] cfg_active_level = DEFAULT_ACTIVE_LEVEL;
    logic signed [15:0] cfg_idle_level = -16'sd1;
    logic [7:0]         cfg_step = 8'd0;
    logic [15:0]        cfg_hold = 16'd10;
    logic [31:0]        m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready = 1'b1;
    logic               busy;

    int total = 0;
    int bad = 0;

    axis_level_sequencer dut (
        .aclk             (aclk),
        .areset           (areset),
        .state_data       (state_data),
        .cfg_active_level (cfg_active_level),
        .cfg_idle_level   (cfg_idle_level),
        .cfg_step         (cfg_step),
        .cfg_hold         (cfg_hold),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .busy             (busy)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int slew(input int lvl, input int tgt, input int st);
        int d;
        d = tgt - lvl;
        if (st == 0 || (d < 0 ? -d : d) <= st) return tgt;
        return (d > 0) ? lvl + st : lvl - st;
    endfunction

    // Reference model: pin seen two edges late, wait hold+1 stable cycles, then slew on beats.
    int m_level;
    int m_wait;
    bit m_valid, m_comm, m_pend, m_ramp, m_busy, m_pin1, m_pin2;

    always @(posedge aclk or posedge areset) begin : model
        int tgt;
        int nl;
        if (areset) begin
            m_level = -1; m_wait = 0; m_valid = 0; m_comm = 0;
            m_pend = 0; m_ramp = 0; m_busy = 0; m_pin1 = 0; m_pin2 = 0;
        end else begin
            tgt = m_comm ? int'(cfg_active_level) : int'(cfg_idle_level);
            nl = (m_valid && m_axis_tready) ? slew(m_level, tgt, int'(cfg_step)) : m_level;
            if (m_pend) begin
                if (m_pin2 == m_comm) begin
                    m_pend = 0;
                    m_ramp = (m_level != tgt);
                end else if (m_wait == 0) begin
                    m_comm = m_pin2;
                    m_pend = 0;
                    m_ramp = 1;
                end else begin
                    m_wait = m_wait - 1;
                end
            end else if (m_pin2 != m_comm) begin
                m_pend = 1;
                m_ramp = 0;
                m_wait = int'(cfg_hold);
            end else begin
                m_ramp = (m_level != tgt);
            end
            m_busy = m_pend || m_ramp;
            m_pin2 = m_pin1;
            m_pin1 = state_data;
            m_level = nl;
            m_valid = 1;
        end
    end

    always @(negedge aclk) begin
        check("tvalid", 32'(m_axis_tvalid), 32'(m_valid));
        check("tdata", m_axis_tdata, 32'(m_level));
        check("busy", 32'(busy), 32'(m_busy));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // Follows a ramp with tready high; each new sample must be exactly one step further.
    task automatic collect(input string nm, input int base, input int fin, input int st,
                           input int exp_n, input int budget);
        int n;
        int k;
        int dir;
        int e;
        logic [31:0] last;
        n = 0;
        k = 0;
        dir = (fin > base) ? 1 : -1;
        last = m_axis_tdata;
        check({nm, "_start"}, last, 32'(base));
        while (last != 32'(fin) && k < budget) begin
            @(negedge aclk);
            k++;
            if (m_axis_tdata != last) begin
                n++;
                last = m_axis_tdata;
                e = base + dir * st * n;
                if (dir > 0 && e > fin) e = fin;
                if (dir < 0 && e < fin) e = fin;
                check({nm, "_sample"}, last, 32'(e));
            end
        end
        if (k >= budget) check({nm, "_timeout"}, 32'(0), 32'(1));
        check({nm, "_beats"}, 32'(n), 32'(exp_n));
    endtask

    task automatic wait_for(input string nm, input logic [31:0] val, input int budget);
        int k;
        k = 0;
        while (m_axis_tdata != val && k < budget) begin
            @(negedge aclk);
            k++;
        end
        if (k >= budget) check({nm, "_timeout"}, 32'(0), 32'(1));
    endtask

    initial begin : stim
        int nbusy;
        logic [31:0] frozen;

        tick(2);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
        check("rst_tdata", m_axis_tdata, 32'hFFFF_FFFF);
        areset = 1'b0;
        tick(1);
        check("start_tvalid", 32'(m_axis_tvalid), 32'h1);
        check("start_tdata", m_axis_tdata, 32'hFFFF_FFFF);
        check("start_busy", 32'(busy), 32'h0);

        // Three-cycle glitch against hold=10 must not commit.
        state_data = 1'b1;
        nbusy = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge aclk);
            if (k == 3) state_data = 1'b0;
            if (busy) nbusy++;
        end
        check("glitch_busy_cycles", 32'(nbusy), 32'd3);
        check("glitch_tdata", m_axis_tdata, 32'hFFFF_FFFF);

        // hold=4, step=0: jump after 2 sync + 5 debounce cycles + commit edge.
        cfg_hold = 16'd4;
        state_data = 1'b1;
        tick(2);
        check("sync_busy_low", 32'(busy), 32'h0);
        tick(1);
        check("debounce_busy", 32'(busy), 32'h1);
        tick(5);
        check("jump_not_yet", m_axis_tdata, 32'hFFFF_FFFF);
        tick(1);
        check("jump_tdata", m_axis_tdata, 32'h0000_02FF);
        check("jump_busy", 32'(busy), 32'h1);
        tick(1);
        check("jump_settled", 32'(busy), 32'h0);

        // Back to idle instantly, then ramp both ways with step 0x40.
        cfg_hold = 16'd0;
        state_data = 1'b0;
        tick(8);
        check("idle_again", m_axis_tdata, 32'hFFFF_FFFF);
        cfg_step = 8'h40;
        state_data = 1'b1;
        collect("ramp_up", -1, 767, 64, 12, 60);
        state_data = 1'b0;
        collect("ramp_down", 767, -1, 64, 12, 60);

        // Back-pressure mid-ramp.
        state_data = 1'b1;
        wait_for("bp_reach", 32'd127, 40);
        m_axis_tready = 1'b0;
        frozen = m_axis_tdata;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("bp_frozen", m_axis_tdata, frozen);
        end
        m_axis_tready = 1'b1;
        tick(1);
        check("bp_resume", m_axis_tdata, 32'd191);
        wait_for("bp_finish", 32'd767, 40);

        // Full-scale swing at step 255.
        cfg_step = 8'd0;
        cfg_idle_level = -16'sd32768;
        cfg_active_level = 16'sd32767;
        state_data = 1'b0;
        tick(8);
        check("fs_low", m_axis_tdata, 32'hFFFF_8000);
        cfg_step = 8'hFF;
        state_data = 1'b1;
        collect("fs_up", -32768, 32767, 255, 257, 400);

        // Asynchronous reset in the middle of a downward ramp.
        state_data = 1'b0;
        tick(8);
        @(posedge aclk);
        #2;
        areset = 1'b1;
        cfg_idle_level = -16'sd1;
        #1;
        check("midrst_tvalid", 32'(m_axis_tvalid), 32'h0);
        check("midrst_tdata", m_axis_tdata, 32'hFFFF_FFFF);
        check("midrst_busy", 32'(busy), 32'h0);
        @(negedge aclk);
        areset = 1'b0;
        tick(2);
        check("restart_tvalid", 32'(m_axis_tvalid), 32'h1);
        check("restart_tdata", m_axis_tdata, 32'hFFFF_FFFF);
        check("restart_busy", 32'(busy), 32'h0);
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
